sreg_write_ctrl: RTL

Parametrised special-register write controller: the successor to the combinational special-register select decoder. It accepts write requests over a valid/ready handshake, buffers them in a small FIFO, and issues registered one-hot write-enable pulses with data to the special-register bank. It sits between the control unit and the special-register bank. It also provides:
- stall back-pressure from the bank;
- per-register write locking;
- sticky error reporting for out-of-range and locked selects;
- a completed-write counter.

---
 rtl/sreg_write_ctrl.sv | 108 ++++++++++
 1 files changed

// File: rtl/sreg_write_ctrl.sv
// Special-register write controller: buffers write requests in a small FIFO and
// issues registered one-hot write-enable pulses with data to the register bank.
module sreg_write_ctrl #(
    parameter int NUM_REGS = 8,
    parameter int SEL_W    = 4,
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [SEL_W-1:0]    req_sel,
    input  logic [DATA_W-1:0]   req_data,
    input  logic [NUM_REGS-1:0] lock_mask,
    input  logic                stall,
    output logic [NUM_REGS-1:0] wr_en,
    output logic [DATA_W-1:0]   wr_data,
    output logic                err_range,
    output logic                err_lock,
    input  logic                err_clr,
    output logic [7:0]          wr_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]    FULL_LVL   = (AW + 1)'(DEPTH);
    localparam logic [SEL_W:0] NUM_REGS_C = (SEL_W + 1)'(NUM_REGS);

    logic [SEL_W-1:0]  sel_mem  [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;

    logic                push;
    logic                pop;
    logic                empty;
    logic [SEL_W-1:0]    head_sel;
    logic [DATA_W-1:0]   head_data;
    logic [NUM_REGS-1:0] head_onehot;
    logic                in_range;
    logic                locked;
    logic                issue_ok;
    logic                range_err;
    logic                lock_err;

    // The issue FSM collapses onto the FIFO empty flag: ISSUE == !empty && !stall.
    assign empty     = (count == '0);
    assign req_ready = (count != FULL_LVL);
    assign push      = req_valid && req_ready;
    assign pop       = !empty && !stall;

    assign head_sel  = sel_mem[rd_ptr];
    assign head_data = data_mem[rd_ptr];

    always_comb begin
        // NOTE: default first so no path leaves head_onehot unassigned (no latch).
        head_onehot = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            head_onehot[i] = (head_sel == SEL_W'(i));
        end
    end

    // An out-of-range select has an all-zero one-hot, so it can never look locked.
    assign in_range  = ({1'b0, head_sel} < NUM_REGS_C);
    assign locked    = |(head_onehot & lock_mask);
    assign issue_ok  = pop && in_range && !locked;
    assign range_err = pop && !in_range;
    assign lock_err  = pop && in_range && locked;

    // NOTE: FIFO storage is not reset; the pointers and count alone define validity.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            sel_mem[wr_ptr]  <= req_sel;
            data_mem[wr_ptr] <= req_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            wr_en     <= '0;
            wr_data   <= '0;
            err_range <= 1'b0;
            err_lock  <= 1'b0;
            wr_count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;

            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;

            wr_en <= issue_ok ? head_onehot : '0;
            if (issue_ok) begin
                wr_data  <= head_data;
                wr_count <= wr_count + 8'd1;
            end

            // A new error on the same edge as err_clr wins over the clear.
            err_range <= (err_range && !err_clr) || range_err;
            err_lock  <= (err_lock  && !err_clr) || lock_err;
        end
    end

endmodule
